mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_if.sv | 31 +++
 rtl/mem_stage.sv | 185 ++++++++++++++++++
 tb/tb_mem_stage.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_if
// Brief    : Data-memory request/response bus between the MEM stage and the
//            data memory (request, write strobe, address, byte enables, write
//            data, grant, read-valid, read data).
// Revision : 1.0 - initial release
// ============================================================================
interface mem_stage_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  // Pipeline side: issues requests, consumes grant and read data
  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );

  // Memory side: accepts requests, returns grant and read data
  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Brief    : RV32 memory pipeline stage. Passes ALU results through, issues
//            aligned loads/stores on the data-memory bus, formats load data
//            and flags misaligned accesses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        ex_valid_i,
  output logic             ready_o,
  input  wire logic        ex_mem_re_i,
  input  wire logic        ex_mem_we_i,
  input  wire logic [2:0]  ex_funct3_i,
  input  wire logic        ex_rd_we_i,
  input  wire logic [4:0]  ex_rd_waddr_i,
  input  wire logic [31:0] ex_result_i,
  input  wire logic [31:0] ex_store_data_i,
  mem_stage_if.master      dmem,
  output logic             rd_we_o,
  output logic [4:0]       rd_waddr_o,
  output logic [31:0]      rd_data_o,
  output logic             misalign_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;

  // Captured instruction context
  logic        r_we;
  logic [1:0]  r_off;
  logic [2:0]  r_funct3;
  logic        r_rd_we;
  logic [4:0]  r_rd_waddr;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;

  // Registered write-back bundle
  logic        r_wb_we;
  logic [4:0]  r_wb_waddr;
  logic [31:0] r_wb_data;
  logic        r_misalign;

  // Decode of the instruction offered by EX
  logic        w_accept;
  logic        w_is_mem;
  logic        w_is_byte;
  logic        w_is_half;
  logic        w_is_word;
  logic [1:0]  w_off;
  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_lane;
  logic [31:0] w_load_data;

  assign w_accept   = (r_state == S_IDLE) && ex_valid_i;
  assign w_is_mem   = ex_mem_re_i || ex_mem_we_i;
  assign w_is_byte  = (ex_funct3_i == F3_B) || (ex_funct3_i == F3_BU);
  assign w_is_half  = (ex_funct3_i == F3_H) || (ex_funct3_i == F3_HU);
  assign w_is_word  = !w_is_byte && !w_is_half;
  assign w_off      = ex_result_i[1:0];
  assign w_misalign = (w_is_half && w_off[0]) || (w_is_word && (w_off != 2'b00));

  // Byte enables and lane-replicated write data for the offered access
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = ex_store_data_i;
    if (w_is_byte) begin
      w_be    = 4'b0001 << w_off;
      w_wdata = {4{ex_store_data_i[7:0]}};
    end else if (w_is_half) begin
      w_be    = w_off[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{ex_store_data_i[15:0]}};
    end
  end

  // Shift the addressed lane to bit 0, then sign/zero extend by access size
  assign w_lane = dmem.dmem_rdata_i >> {r_off, 3'b000};

  always_comb begin
    case (r_funct3)
      F3_B:    w_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
      F3_BU:   w_load_data = {24'd0, w_lane[7:0]};
      F3_H:    w_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
      F3_HU:   w_load_data = {16'd0, w_lane[15:0]};
      default: w_load_data = w_lane;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: only aligned memory ops leave IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_is_mem && !w_misalign) w_state_nxt = S_REQ;
      S_REQ:  if (dmem.dmem_gnt_i) w_state_nxt = r_we ? S_IDLE : S_WAIT;
      S_WAIT: if (dmem.dmem_rvalid_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM-decoded outputs
  always_comb begin
    ready_o         = (r_state == S_IDLE);
    dmem.dmem_req_o = (r_state == S_REQ);
    dmem.dmem_we_o  = (r_state == S_REQ) && r_we;
  end

  // Capture the accepted instruction and its bus fields; held until the next accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_off      <= 2'b00;
      r_funct3   <= 3'b000;
      r_rd_we    <= 1'b0;
      r_rd_waddr <= 5'd0;
      r_addr     <= 32'd0;
      r_be       <= 4'd0;
      r_wdata    <= 32'd0;
    end else if (w_accept) begin
      r_we       <= ex_mem_we_i;
      r_off      <= w_off;
      r_funct3   <= ex_funct3_i;
      r_rd_we    <= ex_rd_we_i;
      r_rd_waddr <= ex_rd_waddr_i;
      if (w_is_mem && !w_misalign) begin
        r_addr  <= {ex_result_i[31:2], 2'b00};
        r_be    <= w_be;
        r_wdata <= w_wdata;
      end
    end
  end

  // Write-back bundle and misalign flag; the strobes are single-cycle pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_we    <= 1'b0;
      r_wb_waddr <= 5'd0;
      r_wb_data  <= 32'd0;
      r_misalign <= 1'b0;
    end else begin
      r_wb_we    <= 1'b0;
      r_misalign <= 1'b0;
      if (w_accept && !w_is_mem) begin
        r_wb_we    <= ex_rd_we_i;
        r_wb_waddr <= ex_rd_waddr_i;
        r_wb_data  <= ex_result_i;
      end else if (w_accept && w_misalign) begin
        r_misalign <= 1'b1;
      end else if ((r_state == S_WAIT) && dmem.dmem_rvalid_i) begin
        r_wb_we    <= r_rd_we;
        r_wb_waddr <= r_rd_waddr;
        r_wb_data  <= w_load_data;
      end
    end
  end

  assign dmem.dmem_addr_o  = r_addr;
  assign dmem.dmem_be_o    = r_be;
  assign dmem.dmem_wdata_o = r_wdata;
  assign rd_we_o           = r_wb_we;
  assign rd_waddr_o        = r_wb_waddr;
  assign rd_data_o         = r_wb_data;
  assign misalign_o        = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Brief    : Directed self-checking bench for mem_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        ex_valid_i;
  logic        ready_o;
  logic        ex_mem_re_i;
  logic        ex_mem_we_i;
  logic [2:0]  ex_funct3_i;
  logic        ex_rd_we_i;
  logic [4:0]  ex_rd_waddr_i;
  logic [31:0] ex_result_i;
  logic [31:0] ex_store_data_i;
  logic        rd_we_o;
  logic [4:0]  rd_waddr_o;
  logic [31:0] rd_data_o;
  logic        misalign_o;

  int n_checks;
  int n_fail;

  mem_stage_if dmem ();

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid_i      (ex_valid_i),
    .ready_o         (ready_o),
    .ex_mem_re_i     (ex_mem_re_i),
    .ex_mem_we_i     (ex_mem_we_i),
    .ex_funct3_i     (ex_funct3_i),
    .ex_rd_we_i      (ex_rd_we_i),
    .ex_rd_waddr_i   (ex_rd_waddr_i),
    .ex_result_i     (ex_result_i),
    .ex_store_data_i (ex_store_data_i),
    .dmem            (dmem.master),
    .rd_we_o         (rd_we_o),
    .rd_waddr_o      (rd_waddr_o),
    .rd_data_o       (rd_data_o),
    .misalign_o      (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single accepting edge
  task automatic issue(input logic re, input logic we, input logic [2:0] f3,
                       input logic rdwe, input logic [4:0] rd,
                       input logic [31:0] res, input logic [31:0] sd);
    ex_valid_i      = 1'b1;
    ex_mem_re_i     = re;
    ex_mem_we_i     = we;
    ex_funct3_i     = f3;
    ex_rd_we_i      = rdwe;
    ex_rd_waddr_i   = rd;
    ex_result_i     = res;
    ex_store_data_i = sd;
    step();
    ex_valid_i      = 1'b0;
  endtask

  // Grant now, then return read data after idle_cycles extra WAIT cycles
  task automatic grant_and_read(input int idle_cycles, input logic [31:0] rdata);
    dmem.dmem_gnt_i = 1'b1;
    step();
    dmem.dmem_gnt_i = 1'b0;
    for (int i = 0; i < idle_cycles; i++) step();
    dmem.dmem_rvalid_i = 1'b1;
    dmem.dmem_rdata_i  = rdata;
    step();
    dmem.dmem_rvalid_i = 1'b0;
    dmem.dmem_rdata_i  = 32'd0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    ex_valid_i = 1'b0; ex_mem_re_i = 1'b0; ex_mem_we_i = 1'b0; ex_funct3_i = 3'b000;
    ex_rd_we_i = 1'b0; ex_rd_waddr_i = 5'd0; ex_result_i = 32'd0; ex_store_data_i = 32'd0;
    dmem.dmem_gnt_i = 1'b0; dmem.dmem_rvalid_i = 1'b0; dmem.dmem_rdata_i = 32'd0;

    // Reset state
    repeat (2) step();
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_req", {31'd0, dmem.dmem_req_o}, 32'd0);
    chk("rst_rdwe", {31'd0, rd_we_o}, 32'd0);
    chk("rst_addr", dmem.dmem_addr_o, 32'd0);
    rst = 1'b0;
    step();

    // ALU pass-through
    issue(1'b0, 1'b0, 3'b000, 1'b1, 5'd5, 32'h0000_1234, 32'd0);
    chk("alu_rdwe", {31'd0, rd_we_o}, 32'd1);
    chk("alu_waddr", {27'd0, rd_waddr_o}, 32'd5);
    chk("alu_data", rd_data_o, 32'h0000_1234);
    chk("alu_ready", {31'd0, ready_o}, 32'd1);
    step();
    chk("alu_pulse", {31'd0, rd_we_o}, 32'd0);

    // LB 0x103, rdata after gnt + 2 idle cycles
    issue(1'b1, 1'b0, 3'b000, 1'b1, 5'd7, 32'h0000_0103, 32'd0);
    chk("lb_ready", {31'd0, ready_o}, 32'd0);
    chk("lb_req", {31'd0, dmem.dmem_req_o}, 32'd1);
    chk("lb_addr", dmem.dmem_addr_o, 32'h0000_0100);
    chk("lb_be", {28'd0, dmem.dmem_be_o}, 32'h8);
    chk("lb_we", {31'd0, dmem.dmem_we_o}, 32'd0);
    dmem.dmem_gnt_i = 1'b1;
    step();
    dmem.dmem_gnt_i = 1'b0;
    chk("lb_wait_req", {31'd0, dmem.dmem_req_o}, 32'd0);
    repeat (2) step();
    chk("lb_wait_ready", {31'd0, ready_o}, 32'd0);
    dmem.dmem_rvalid_i = 1'b1;
    dmem.dmem_rdata_i  = 32'h80FF_0011;
    step();
    dmem.dmem_rvalid_i = 1'b0;
    chk("lb_rdwe", {31'd0, rd_we_o}, 32'd1);
    chk("lb_waddr", {27'd0, rd_waddr_o}, 32'd7);
    chk("lb_data", rd_data_o, 32'hFFFF_FF80);
    chk("lb_ready_back", {31'd0, ready_o}, 32'd1);
    step();
    chk("lb_pulse", {31'd0, rd_we_o}, 32'd0);

    // LHU 0x102
    issue(1'b1, 1'b0, 3'b101, 1'b1, 5'd9, 32'h0000_0102, 32'd0);
    chk("lhu_addr", dmem.dmem_addr_o, 32'h0000_0100);
    chk("lhu_be", {28'd0, dmem.dmem_be_o}, 32'hC);
    grant_and_read(0, 32'h8001_0000);
    chk("lhu_data", rd_data_o, 32'h0000_8001);

    // LH 0x100 sign-extends
    issue(1'b1, 1'b0, 3'b001, 1'b1, 5'd10, 32'h0000_0100, 32'd0);
    chk("lh_be", {28'd0, dmem.dmem_be_o}, 32'h3);
    grant_and_read(1, 32'h0000_8001);
    chk("lh_data", rd_data_o, 32'hFFFF_8001);

    // LBU 0x101
    issue(1'b1, 1'b0, 3'b100, 1'b1, 5'd11, 32'h0000_0101, 32'd0);
    grant_and_read(0, 32'h1234_F600);
    chk("lbu_data", rd_data_o, 32'h0000_00F6);

    // SB 0x201 with grant delayed 3 cycles; an EX offer meanwhile is ignored
    issue(1'b0, 1'b1, 3'b000, 1'b0, 5'd0, 32'h0000_0201, 32'h0000_00AB);
    chk("sb_be", {28'd0, dmem.dmem_be_o}, 32'h2);
    chk("sb_wdata", dmem.dmem_wdata_o, 32'hABAB_ABAB);
    chk("sb_addr", dmem.dmem_addr_o, 32'h0000_0200);
    for (int i = 0; i < 3; i++) begin
      chk("sb_req_held", {31'd0, dmem.dmem_req_o}, 32'd1);
      chk("sb_we_held", {31'd0, dmem.dmem_we_o}, 32'd1);
      issue(1'b0, 1'b0, 3'b000, 1'b1, 5'd3, 32'hDEAD_0000, 32'd0);
      chk("sb_ignored", {31'd0, rd_we_o}, 32'd0);
    end
    chk("sb_req4", {31'd0, dmem.dmem_req_o}, 32'd1);
    chk("sb_be_stable", {28'd0, dmem.dmem_be_o}, 32'h2);
    dmem.dmem_gnt_i = 1'b1;
    step();
    dmem.dmem_gnt_i = 1'b0;
    chk("sb_done_req", {31'd0, dmem.dmem_req_o}, 32'd0);
    chk("sb_done_ready", {31'd0, ready_o}, 32'd1);
    chk("sb_rdwe", {31'd0, rd_we_o}, 32'd0);

    // SH 0x202 and SW 0x300
    issue(1'b0, 1'b1, 3'b001, 1'b0, 5'd0, 32'h0000_0202, 32'h1234_5678);
    chk("sh_be", {28'd0, dmem.dmem_be_o}, 32'hC);
    chk("sh_wdata", dmem.dmem_wdata_o, 32'h5678_5678);
    dmem.dmem_gnt_i = 1'b1; step(); dmem.dmem_gnt_i = 1'b0;
    issue(1'b0, 1'b1, 3'b010, 1'b0, 5'd0, 32'h0000_0300, 32'hCAFE_F00D);
    chk("sw_be", {28'd0, dmem.dmem_be_o}, 32'hF);
    chk("sw_wdata", dmem.dmem_wdata_o, 32'hCAFE_F00D);
    dmem.dmem_gnt_i = 1'b1; step(); dmem.dmem_gnt_i = 1'b0;
    chk("sw_idle", {31'd0, ready_o}, 32'd1);

    // Misaligned LW 0x106 and LH 0x101
    issue(1'b1, 1'b0, 3'b010, 1'b1, 5'd12, 32'h0000_0106, 32'd0);
    chk("lw_mis", {31'd0, misalign_o}, 32'd1);
    chk("lw_mis_req", {31'd0, dmem.dmem_req_o}, 32'd0);
    chk("lw_mis_rdwe", {31'd0, rd_we_o}, 32'd0);
    chk("lw_mis_ready", {31'd0, ready_o}, 32'd1);
    step();
    chk("lw_mis_pulse", {31'd0, misalign_o}, 32'd0);
    chk("lw_mis_req2", {31'd0, dmem.dmem_req_o}, 32'd0);
    issue(1'b1, 1'b0, 3'b001, 1'b1, 5'd12, 32'h0000_0101, 32'd0);
    chk("lh_mis", {31'd0, misalign_o}, 32'd1);

    // Reset during WAIT, late rvalid afterwards
    issue(1'b1, 1'b0, 3'b010, 1'b1, 5'd13, 32'h0000_0400, 32'd0);
    chk("lw_req", {31'd0, dmem.dmem_req_o}, 32'd1);
    dmem.dmem_gnt_i = 1'b1; step(); dmem.dmem_gnt_i = 1'b0;
    chk("lw_wait_ready", {31'd0, ready_o}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_ready", {31'd0, ready_o}, 32'd1);
    chk("async_addr", dmem.dmem_addr_o, 32'd0);
    chk("async_be", {28'd0, dmem.dmem_be_o}, 32'd0);
    chk("async_wdata", dmem.dmem_wdata_o, 32'd0);
    chk("async_data", rd_data_o, 32'd0);
    step();
    rst = 1'b0;
    step();
    dmem.dmem_rvalid_i = 1'b1;
    dmem.dmem_rdata_i  = 32'h5555_AAAA;
    step();
    dmem.dmem_rvalid_i = 1'b0;
    chk("late_rvalid_rdwe", {31'd0, rd_we_o}, 32'd0);
    chk("late_rvalid_ready", {31'd0, ready_o}, 32'd1);
    step();
    chk("late_rvalid_rdwe2", {31'd0, rd_we_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
